// File: rtl/drp_rmw_sequencer.sv
// Walks a CSR-loaded table of DRP read-modify-write entries, issuing read/write commands to the DRP controller.
// Writes are skipped when the merged value already equals the read data; each wait is bounded by TIMEOUT_CYCLES.
module drp_rmw_sequencer #(
  parameter int DRP_ADDR_WIDTH    = 10,
  parameter int DRP_DATA_WIDTH    = 16,
  parameter int TABLE_INDEX_WIDTH = 4,
  parameter int TIMEOUT_CYCLES    = 1023
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tableWe,
  input  logic [TABLE_INDEX_WIDTH-1:0] tableIndex,
  input  logic [DRP_ADDR_WIDTH-1:0]    tableAddr,
  input  logic [DRP_DATA_WIDTH-1:0]    tableMask,
  input  logic [DRP_DATA_WIDTH-1:0]    tableValue,
  input  logic [TABLE_INDEX_WIDTH:0]   entryCount,
  input  logic                         start,
  input  logic                         abort,
  output logic                         drpStrobe,
  output logic [31:0]                  drpCommand,
  input  logic [31:0]                  drpStatus,
  output logic                         seqBusy,
  output logic                         seqDone,
  output logic [1:0]                   errorCode,
  output logic [TABLE_INDEX_WIDTH-1:0] errorIndex,
  output logic [TABLE_INDEX_WIDTH:0]   writesIssued
);
  localparam int ENTRIES = 1 << TABLE_INDEX_WIDTH;
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ABORT   = 2'd2;

  typedef enum logic [3:0] {
    IDLE, RD_ISSUE, RD_GUARD, RD_WAIT, WR_ISSUE, WR_GUARD, WR_WAIT, NEXT, FINISH
  } state_t;

  state_t state, state_nxt;

  logic [DRP_ADDR_WIDTH-1:0] addr_mem  [ENTRIES];
  logic [DRP_DATA_WIDTH-1:0] mask_mem  [ENTRIES];
  logic [DRP_DATA_WIDTH-1:0] value_mem [ENTRIES];

  logic [TABLE_INDEX_WIDTH-1:0] idx, last_idx;
  logic [TW-1:0]                wait_cnt;
  logic                         abort_q, zero_done;
  logic [DRP_DATA_WIDTH-1:0]    rd_data, merged, merged_q;
  logic [31:0]                  cmd_rd, cmd_wr, cmd_hold;
  logic                         busy_in, wait_st, timed_out, last_entry;
  logic                         unused_status;

  assign busy_in       = drpStatus[31];
  assign rd_data       = drpStatus[DRP_DATA_WIDTH-1:0];
  assign unused_status = ^drpStatus[30:DRP_DATA_WIDTH];
  assign merged        = (rd_data & ~mask_mem[idx]) | (value_mem[idx] & mask_mem[idx]);
  assign wait_st       = (state == RD_WAIT) || (state == WR_WAIT);
  assign timed_out     = wait_st && busy_in && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign last_entry    = (idx == last_idx);

  always_comb begin
    cmd_rd = '0;
    cmd_rd[16 +: DRP_ADDR_WIDTH] = addr_mem[idx];
    cmd_wr = '0;
    cmd_wr[31] = 1'b1;
    cmd_wr[16 +: DRP_ADDR_WIDTH] = addr_mem[idx];
    cmd_wr[DRP_DATA_WIDTH-1:0] = merged_q;
  end

  // The command word is live only during a strobe and otherwise replays the last one issued.
  assign drpStrobe  = (state == RD_ISSUE) || (state == WR_ISSUE);
  assign drpCommand = (state == RD_ISSUE) ? cmd_rd :
                      (state == WR_ISSUE) ? cmd_wr : cmd_hold;
  assign seqBusy    = (state != IDLE) && (state != FINISH);
  assign seqDone    = (state == FINISH) || zero_done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && entryCount != '0) state_nxt = RD_ISSUE;
      RD_ISSUE: state_nxt = RD_GUARD;
      RD_GUARD: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (!busy_in)       state_nxt = (merged == rd_data) ? NEXT : WR_ISSUE;
        else if (timed_out) state_nxt = FINISH;
      end
      WR_ISSUE: state_nxt = WR_GUARD;
      WR_GUARD: state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (!busy_in)       state_nxt = NEXT;
        else if (timed_out) state_nxt = FINISH;
      end
      NEXT:     state_nxt = (abort_q || last_entry) ? FINISH : RD_ISSUE;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      idx          <= '0;
      last_idx     <= '0;
      wait_cnt     <= '0;
      abort_q      <= 1'b0;
      zero_done    <= 1'b0;
      merged_q     <= '0;
      cmd_hold     <= '0;
      errorCode    <= ERR_OK;
      errorIndex   <= '0;
      writesIssued <= '0;
    end else begin
      state     <= state_nxt;
      cmd_hold  <= drpCommand;
      zero_done <= (state == IDLE) && start && (entryCount == '0);
      wait_cnt  <= wait_st ? wait_cnt + TW'(1) : '0;
      if (state == IDLE && start) begin
        abort_q      <= 1'b0;
        idx          <= '0;
        last_idx     <= TABLE_INDEX_WIDTH'(entryCount - (TABLE_INDEX_WIDTH + 1)'(1));
        errorCode    <= ERR_OK;
        errorIndex   <= '0;
        writesIssued <= '0;
      end else if (seqBusy && abort) begin
        abort_q <= 1'b1;
      end
      if (state == RD_WAIT && !busy_in) merged_q <= merged;
      if (state == WR_ISSUE) writesIssued <= writesIssued + (TABLE_INDEX_WIDTH + 1)'(1);
      // A timeout ends the run from the wait state, so it wins over any pending abort.
      if (timed_out) begin
        errorCode  <= ERR_TIMEOUT;
        errorIndex <= idx;
      end
      if (state == NEXT) begin
        if (abort_q) begin
          errorCode  <= ERR_ABORT;
          errorIndex <= idx;
        end else if (!last_entry) begin
          idx <= idx + TABLE_INDEX_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tableWe && state == IDLE) begin
      addr_mem[tableIndex]  <= tableAddr;
      mask_mem[tableIndex]  <= tableMask;
      value_mem[tableIndex] <= tableValue;
    end
  end
endmodule

// File: tb/tb_drp_rmw_sequencer.sv
// Bench for drp_rmw_sequencer: DRP controller model with a register file and
// configurable busy time, plus a table-level reference of expected accesses.
module tb_drp_rmw_sequencer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tableWe = 1'b0;
  logic [3:0]  tableIndex = '0;
  logic [9:0]  tableAddr = '0;
  logic [15:0] tableMask = '0;
  logic [15:0] tableValue = '0;
  logic [4:0]  entryCount = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        drpStrobe;
  logic [31:0] drpCommand;
  logic [31:0] drpStatus;
  logic        seqBusy;
  logic        seqDone;
  logic [1:0]  errorCode;
  logic [3:0]  errorIndex;
  logic [4:0]  writesIssued;

  drp_rmw_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .tableWe(tableWe), .tableIndex(tableIndex),
    .tableAddr(tableAddr), .tableMask(tableMask), .tableValue(tableValue),
    .entryCount(entryCount), .start(start), .abort(abort),
    .drpStrobe(drpStrobe), .drpCommand(drpCommand), .drpStatus(drpStatus),
    .seqBusy(seqBusy), .seqDone(seqDone), .errorCode(errorCode),
    .errorIndex(errorIndex), .writesIssued(writesIssued)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Controller model: busy rises the cycle after a strobe and stays for `lat` cycles.
  logic        model_clr = 1'b0;
  int          lat = 0;
  int          hang_at = -1;
  logic [15:0] init_regs [1024];
  logic [15:0] drp_regs  [1024];
  logic [15:0] rdata = '0;
  int          busy_cnt = 0;
  logic        hang = 1'b0;
  int          reads_seen = 0;
  int          viol = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          cyc = 0;
  logic [31:0] acc_q[$];
  int          acc_cyc[$];
  logic        busy_now;

  assign busy_now  = hang || (busy_cnt > 0);
  assign drpStatus = {busy_now, 15'd0, busy_now ? ~rdata : rdata};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (model_clr) begin
      for (int i = 0; i < 1024; i++) drp_regs[i] <= init_regs[i];
      acc_q.delete();
      acc_cyc.delete();
      busy_cnt <= 0; hang <= 1'b0; reads_seen <= 0; viol <= 0; done_cnt <= 0;
    end else begin
      if (seqDone) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (drpStrobe) begin
        if (busy_now) viol <= viol + 1;
        acc_q.push_back(drpCommand);
        acc_cyc.push_back(cyc);
        if (drpCommand[31]) drp_regs[drpCommand[25:16]] <= drpCommand[15:0];
        else begin
          rdata <= drp_regs[drpCommand[25:16]];
          if (reads_seen == hang_at) hang <= 1'b1;
          reads_seen <= reads_seen + 1;
        end
        busy_cnt <= lat;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  // Table shadow and reference expectations.
  logic [9:0]  t_addr [16];
  logic [15:0] t_mask [16];
  logic [15:0] t_val  [16];
  logic [15:0] ref_regs [1024];
  logic [31:0] exp_q[$];
  int          exp_writes;

  task automatic ref_run(input int n);
    logic [15:0] r, m;
    exp_q.delete();
    exp_writes = 0;
    for (int i = 0; i < 1024; i++) ref_regs[i] = init_regs[i];
    for (int i = 0; i < n; i++) begin
      r = ref_regs[t_addr[i]];
      m = (r & ~t_mask[i]) | (t_val[i] & t_mask[i]);
      exp_q.push_back({6'd0, t_addr[i], 16'h0000});
      if (m != r) begin
        exp_q.push_back({1'b1, 5'd0, t_addr[i], m});
        ref_regs[t_addr[i]] = m;
        exp_writes++;
      end
    end
  endtask

  task automatic model_clear();
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
  endtask

  task automatic load_entry(input int i, input logic [9:0] a, input logic [15:0] m, input logic [15:0] v);
    @(negedge clk);
    tableWe = 1'b1; tableIndex = 4'(i); tableAddr = a; tableMask = m; tableValue = v;
    t_addr[i] = a; t_mask[i] = m; t_val[i] = v;
    @(negedge clk);
    tableWe = 1'b0;
  endtask

  task automatic run_seq(input int n, input bit with_abort, output bit got_done);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    entryCount = 5'(n); start = 1'b1; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    got_done = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (done_cnt != d0) begin got_done = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({drpStrobe, drpCommand, seqBusy, seqDone, errorCode, errorIndex, writesIssued} !== '0) begin
      fails++; $display("FAIL reset_outputs: got strobe=%b cmd=%h busy=%b done=%b err=%0d idx=%0d wr=%0d required all 0",
                        drpStrobe, drpCommand, seqBusy, seqDone, errorCode, errorIndex, writesIssued);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    lat = 0; hang_at = -1;
    init_regs[10'h012] = 16'h1234;
    model_clear();
    load_entry(0, 10'h012, 16'h00F0, 16'h0050);
    run_seq(1, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done: got none required seqDone"); end
    tests++;
    if (acc_q.size() != 2) begin fails++; $display("FAIL basic_count: got %0d accesses required 2", acc_q.size()); end
    else begin
      tests++; if (acc_q[0] !== 32'h00120000) begin fails++; $display("FAIL basic_read: got %h required 00120000", acc_q[0]); end
      tests++; if (acc_q[1] !== 32'h80121254) begin fails++; $display("FAIL basic_write: got %h required 80121254", acc_q[1]); end
      tests++; if (acc_cyc[1] - acc_cyc[0] != 3) begin fails++; $display("FAIL basic_rd_to_wr: got %0d cycles required 3", acc_cyc[1] - acc_cyc[0]); end
    end
    tests++; if (errorCode !== 2'd0) begin fails++; $display("FAIL basic_err: got %0d required 0", errorCode); end
    tests++; if (writesIssued !== 5'd1) begin fails++; $display("FAIL basic_writes: got %0d required 1", writesIssued); end
  endtask

  task automatic test_no_write();
    bit ok;
    lat = 0; hang_at = -1;
    init_regs[10'h030] = 16'h1234;
    model_clear();
    load_entry(0, 10'h030, 16'hFF00, 16'h1200);
    run_seq(1, 1'b0, ok);
    tests++; if (!ok || acc_q.size() != 1) begin fails++; $display("FAIL nowrite_access: got done=%b accesses=%0d required 1/1", ok, acc_q.size()); end
    tests++; if (writesIssued !== 5'd0) begin fails++; $display("FAIL nowrite_writes: got %0d required 0", writesIssued); end
  endtask

  task automatic check_against_ref(input string name, input bit ok);
    tests++; if (!ok) begin fails++; $display("FAIL %s_done: got none required seqDone", name); end
    tests++;
    if (acc_q.size() != exp_q.size()) begin
      fails++; $display("FAIL %s_count: got %0d accesses required %0d", name, acc_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (acc_q[i] !== exp_q[i]) begin fails++; $display("FAIL %s_cmd%0d: got %h required %h", name, i, acc_q[i], exp_q[i]); end
      end
    end
    tests++; if (writesIssued !== 5'(exp_writes)) begin fails++; $display("FAIL %s_writes: got %0d required %0d", name, writesIssued, exp_writes); end
    tests++; if (errorCode !== 2'd0) begin fails++; $display("FAIL %s_err: got %0d required 0", name, errorCode); end
    tests++; if (viol != 0) begin fails++; $display("FAIL %s_strobe_while_busy: got %0d required 0", name, viol); end
  endtask

  task automatic test_serialised();
    bit ok;
    lat = 5; hang_at = -1;
    for (int i = 0; i < 3; i++) init_regs[10'h020 + i] = 16'h0000;
    model_clear();
    for (int i = 0; i < 3; i++) load_entry(i, 10'(10'h020 + i), 16'hFFFF, 16'(i + 1));
    ref_run(3);
    run_seq(3, 1'b0, ok);
    check_against_ref("serial", ok);
  endtask

  task automatic test_random();
    bit ok;
    int n;
    for (int it = 0; it < 6; it++) begin
      lat = $urandom_range(0, 4); hang_at = -1;
      for (int a = 0; a < 8; a++) init_regs[a] = 16'($urandom);
      model_clear();
      for (int i = 0; i < 16; i++)
        load_entry(i, 10'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom), 16'($urandom));
      n = $urandom_range(1, 16);
      ref_run(n);
      run_seq(n, it == 0, ok);
      check_against_ref($sformatf("rand%0d", it), ok);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    lat = 0; hang_at = 1;
    model_clear();
    load_entry(0, 10'h001, 16'h0000, 16'h0000);
    load_entry(1, 10'h002, 16'hFFFF, 16'h1234);
    load_entry(2, 10'h003, 16'hFFFF, 16'h1234);
    run_seq(3, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL timeout_done: got none required seqDone"); end
    tests++;
    if (acc_q.size() != 2) begin fails++; $display("FAIL timeout_count: got %0d accesses required 2", acc_q.size()); end
    else begin
      tests++; if (acc_q[1] !== 32'h00020000) begin fails++; $display("FAIL timeout_read1: got %h required 00020000", acc_q[1]); end
      tests++; if (done_cyc - acc_cyc[1] != 18) begin fails++; $display("FAIL timeout_latency: got %0d cycles strobe->done required 18", done_cyc - acc_cyc[1]); end
    end
    tests++; if (errorCode !== 2'd1) begin fails++; $display("FAIL timeout_err: got %0d required 1", errorCode); end
    tests++; if (errorIndex !== 4'd1) begin fails++; $display("FAIL timeout_idx: got %0d required 1", errorIndex); end
    repeat (30) @(negedge clk);
    tests++; if (acc_q.size() != 2) begin fails++; $display("FAIL timeout_quiet: got %0d accesses required 2", acc_q.size()); end
  endtask

  task automatic test_zero_count();
    int s0;
    s0 = acc_q.size();
    @(negedge clk); entryCount = 5'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++; if (seqDone !== 1'b1 || seqBusy !== 1'b0) begin fails++; $display("FAIL zero_pulse: got done=%b busy=%b required 1/0", seqDone, seqBusy); end
    tests++; if (errorCode !== 2'd0 || writesIssued !== 5'd0) begin fails++; $display("FAIL zero_status: got err=%0d wr=%0d required 0/0", errorCode, writesIssued); end
    @(negedge clk);
    tests++; if (seqDone !== 1'b0) begin fails++; $display("FAIL zero_width: got done=%b required 0", seqDone); end
    tests++; if (acc_q.size() != s0) begin fails++; $display("FAIL zero_strobes: got %0d accesses required %0d", acc_q.size(), s0); end
  endtask

  task automatic test_abort();
    bit ok;
    lat = 5; hang_at = -1;
    for (int i = 0; i < 4; i++) init_regs[i + 4] = 16'h0000;
    model_clear();
    for (int i = 0; i < 4; i++) load_entry(i, 10'(i + 4), 16'hFFFF, 16'hAAAA);
    fork
      run_seq(4, 1'b0, ok);
      begin
        for (int k = 0; k < 200 && acc_q.size() < 2; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    join
    tests++; if (!ok) begin fails++; $display("FAIL abort_done: got none required seqDone"); end
    tests++; if (acc_q.size() != 2) begin fails++; $display("FAIL abort_count: got %0d accesses required 2", acc_q.size()); end
    tests++; if (errorCode !== 2'd2) begin fails++; $display("FAIL abort_err: got %0d required 2", errorCode); end
    tests++; if (errorIndex !== 4'd0) begin fails++; $display("FAIL abort_idx: got %0d required 0", errorIndex); end
    tests++; if (writesIssued !== 5'd1) begin fails++; $display("FAIL abort_writes: got %0d required 1", writesIssued); end
  endtask

  task automatic test_reset_mid();
    int d0;
    lat = 20; hang_at = -1;
    model_clear();
    load_entry(0, 10'h03A, 16'hFFFF, 16'h0001);
    @(negedge clk); entryCount = 5'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 50 && acc_q.size() < 1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    tests++; if (seqBusy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b required 1", seqBusy); end
    resetn = 1'b0;
    @(negedge clk);
    tests++;
    if ({drpStrobe, drpCommand, seqBusy, seqDone, errorCode, errorIndex, writesIssued} !== '0) begin
      fails++; $display("FAIL rstmid_outputs: got strobe=%b cmd=%h busy=%b done=%b required all 0", drpStrobe, drpCommand, seqBusy, seqDone);
    end
    resetn = 1'b1;
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    tests++; if (acc_q.size() != 1 || done_cnt != d0) begin fails++; $display("FAIL rstmid_quiet: got accesses=%0d dones=%0d required 1/0", acc_q.size(), done_cnt - d0); end
  endtask

  task automatic test_table_we_busy();
    bit ok;
    int s0;
    lat = 6; hang_at = -1;
    init_regs[10'h005] = 16'h0000;
    model_clear();
    load_entry(0, 10'h005, 16'hFFFF, 16'h5A5A);
    fork
      run_seq(1, 1'b0, ok);
      begin
        for (int k = 0; k < 50 && acc_q.size() < 1; k++) @(negedge clk);
        @(negedge clk);
        tableWe = 1'b1; tableIndex = 4'd0; tableAddr = 10'h009; tableMask = 16'hFFFF; tableValue = 16'h1111;
        @(negedge clk);
        tableWe = 1'b0;
      end
    join
    tests++; if (!ok || writesIssued !== 5'd1) begin fails++; $display("FAIL tblwe_first: got done=%b wr=%0d required 1/1", ok, writesIssued); end
    s0 = acc_q.size();
    run_seq(1, 1'b0, ok);
    tests++; if (!ok || acc_q.size() - s0 != 1) begin fails++; $display("FAIL tblwe_count: got done=%b accesses=%0d required 1/1", ok, acc_q.size() - s0); end
    else begin
      tests++; if (acc_q[s0] !== 32'h00050000) begin fails++; $display("FAIL tblwe_read: got %h required 00050000", acc_q[s0]); end
    end
    tests++; if (writesIssued !== 5'd0) begin fails++; $display("FAIL tblwe_writes: got %0d required 0", writesIssued); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) init_regs[i] = 16'h0000;
    test_reset();
    test_basic();
    test_no_write();
    test_serialised();
    test_random();
    test_timeout();
    test_zero_count();
    test_abort();
    test_reset_mid();
    test_table_we_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule

// File: doc/drp_rmw_sequencer.md
Name: drp_rmw_sequencer

Overview:
- Upstream command source for the DRP controller. It executes a CSR-loaded table of read-modify-write operations against a transceiver/MMCM DRP.
- Drives the controller's strobe and 32-bit command word, and polls the controller's 32-bit status word.
- Used to apply multi-register reconfiguration (e.g. line-rate or clock changes) without software issuing each DRP access.

Parameters:
- DRP_ADDR_WIDTH, 10, DRP address width; must be ≤ 14.
- DRP_DATA_WIDTH, 16, DRP data width; must be ≤ 16.
- TABLE_INDEX_WIDTH, 4, table has 2**TABLE_INDEX_WIDTH entries.
- TIMEOUT_CYCLES, 1023, maximum cycles spent waiting for controller busy to clear per access.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  synchronous active-low reset.
- tableWe  in  1  table write enable.
- tableIndex  in  TABLE_INDEX_WIDTH  entry to write.
- tableAddr  in  DRP_ADDR_WIDTH  entry DRP address.
- tableMask  in  DRP_DATA_WIDTH  entry bit mask; 1 = replace bit.
- tableValue  in  DRP_DATA_WIDTH  entry new bit values.
- entryCount  in  TABLE_INDEX_WIDTH+1  number of entries to run, sampled on start.
- start  in  1  single-cycle request to run entries 0..entryCount-1.
- abort  in  1  request to stop after the outstanding access completes.
- drpStrobe  out  1  one-cycle command strobe to the controller.
- drpCommand  out  32  command word to the controller.
- drpStatus  in  32  controller status: [31] busy, [DRP_DATA_WIDTH-1:0] read data.
- seqBusy  out  1  sequence in progress.
- seqDone  out  1  one-cycle pulse at sequence end, for any reason.
- errorCode  out  2  result of last sequence: 0 ok, 1 timeout, 2 aborted.
- errorIndex  out  TABLE_INDEX_WIDTH  entry index at which a timeout or abort occurred.
- writesIssued  out  TABLE_INDEX_WIDTH+1  count of DRP writes issued in the last sequence.

Behaviour:
- Reset (resetn=0 at a clk edge) forces every output to 0 and the FSM to IDLE. Table RAM contents are not reset.
- Reset mid-operation: return to IDLE the next cycle with no further strobes; any in-flight controller transaction is ignored.
- Command encoding:
  - read: [31]=0, [30]=0, [16+:DRP_ADDR_WIDTH]=addr, all other bits 0.
  - write: [31]=1, [30]=0, addr as above, [15:0]=merged data.
  - Bit 30 is never set.
- drpCommand holds its value outside strobe cycles.
- Table writes are accepted only in IDLE; tableWe while seqBusy=1 is ignored.
- FSM states:
  - IDLE:
    - start with entryCount=0 → seqDone pulse next cycle, errorCode=0, writesIssued=0, remain IDLE.
    - start with entryCount>0 → latch count, index=0, clear errorCode/writesIssued, seqBusy=1, go RD_ISSUE.
    - start while seqBusy=1 is ignored.
  - RD_ISSUE: drpStrobe=1 for exactly one cycle with read command; go RD_GUARD.
  - RD_GUARD: one cycle in which drpStatus is not sampled, because the controller raises busy one cycle after strobe; go RD_WAIT.
  - RD_WAIT: when drpStatus[31]=0, capture read data rd and compute merged = (rd & ~mask) | (value & mask).
    - merged == rd → skip write, go NEXT.
    - otherwise → WR_ISSUE.
  - WR_ISSUE: one-cycle strobe with write command; writesIssued += 1; go WR_GUARD.
  - WR_GUARD: same guard as RD_GUARD; go WR_WAIT.
  - WR_WAIT: drpStatus[31]=0 → NEXT.
  - NEXT:
    - abort latched → errorCode=2, errorIndex=index, go FINISH.
    - index == count-1 → FINISH.
    - otherwise index += 1, go RD_ISSUE.
  - FINISH: seqBusy=0, seqDone=1 for one cycle; go IDLE.
- Timeout: the wait counter restarts on entry to each WAIT state. If drpStatus[31] is still 1 after TIMEOUT_CYCLES cycles in a WAIT state → errorCode=1, errorIndex=index, go FINISH. Timeout takes priority over a latched abort.
- Abort:
  - Latched on any cycle while seqBusy=1; cleared on start.
  - Never interrupts an issued access; takes effect at NEXT.
  - Abort in IDLE is ignored.
  - Abort and start in the same IDLE cycle: start wins, abort discarded.
- Minimum per-entry latency with zero-wait controller: read-only entry 4 cycles (RD_ISSUE, RD_GUARD, RD_WAIT, NEXT); entry with write 7 cycles.
- Status outputs hold until the next start.

Test Plan:
- Load entry0 addr=0x012 mask=0x00F0 value=0x0050; controller model returns 0x1234; start, entryCount=1 → one read 0x00120000, then write 0x80121254; seqDone; errorCode=0; writesIssued=1.
- Entry with mask=0xFF00 value=0x1200 against read 0x1234 → merged equals read, no write strobe, writesIssued=0.
- Three entries, model busy for 5 cycles per access → accesses strictly serialised, no strobe while busy=1, seqDone after the third entry, writesIssued=3.
- Model holds busy=1 forever on the entry-1 read, TIMEOUT_CYCLES=16 → seqDone 16 cycles into RD_WAIT, errorCode=1, errorIndex=1, no further strobes.
- Abort pulsed during the entry-0 write wait of a 4-entry run → write completes, seqDone, errorCode=2, errorIndex=0, no entry-1 read.
- resetn low mid RD_WAIT → next cycle all outputs 0; start with entryCount=0 → seqDone pulse only; tableWe while busy leaves the table unchanged (checked by readback run).
